// File: rtl/syndrome_decoder_if.sv
// syndrome_decoder_if: stream bundle for the (19,6) syndrome decoder.
//   in_valid / in_ready / in_code  : codeword channel into the decoder
//   out_valid / out_ready / out_*  : decoded result channel out of the decoder
// Modports:
//   slave  : the decoder's view (consumes codewords, produces results)
//   master : the environment's view (drives codewords, consumes results)
interface syndrome_decoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [18:0] in_code;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_data;
   logic        out_corrected;
   logic        out_uncorrectable;
   logic [4:0]  out_err_pos;

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_err_pos
   );

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_err_pos
   );
endinterface

// File: rtl/syndrome_decoder.sv
// syndrome_decoder: two-stage (19,6) systematic block decoder.
//   S1 registers the received codeword and its 13-bit syndrome, S2 registers
//   the corrected data plus error flags. Single-bit errors (data or parity)
//   are corrected; any other nonzero syndrome is flagged uncorrectable.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : codeword in / result out valid-ready streams
//   cnt_clear           : synchronous clear of both statistics counters
//   cnt_corrected       : saturating count of delivered corrected words
//   cnt_uncorrectable   : saturating count of delivered uncorrectable words
module syndrome_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   syndrome_decoder_if.slave bus,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] cnt_corrected,
   output logic [CNT_W-1:0] cnt_uncorrectable
);

   // Parity bits p18..p6 packed as [12:0] for data word d.
   function automatic logic [12:0] calc_par(input logic [5:0] d);
      logic [12:0] p;
      p[0]  = d[0] ^ d[1] ^ d[4] ^ d[5];
      p[1]  = d[4] ^ d[5];
      p[2]  = d[2] ^ d[3] ^ d[5];
      p[3]  = d[0] ^ d[3] ^ d[4];
      p[4]  = d[1] ^ d[3] ^ d[4] ^ d[5];
      p[5]  = d[2] ^ d[4];
      p[6]  = d[0] ^ d[1] ^ d[5];
      p[7]  = d[0] ^ d[1] ^ d[4] ^ d[5];
      p[8]  = d[0] ^ d[3];
      p[9]  = d[2] ^ d[4];
      p[10] = d[1] ^ d[3] ^ d[4];
      p[11] = d[1] ^ d[2] ^ d[4] ^ d[5];
      p[12] = d[1] ^ d[2] ^ d[3];
      return p;
   endfunction

   // Syndrome produced by a lone error in codeword bit i. The code is linear,
   // so a data-bit column is just the parity of the matching one-hot word.
   function automatic logic [12:0] col_of(input int i);
      logic [5:0]  d;
      logic [12:0] c;
      d = '0;
      c = '0;
      if (i < 6) begin
         d[i] = 1'b1;
         c    = calc_par(d);
      end else begin
         c[i-6] = 1'b1;
      end
      return c;
   endfunction

   logic        s1_valid, s2_valid;
   logic [18:0] s1_code;
   logic [12:0] s1_syn;
   logic        in_fire, s1_adv, out_fire, s2_ready;

   logic [5:0]  dec_data;
   logic        dec_corr, dec_unc;
   logic [4:0]  dec_pos;

   logic [5:0]  r_data;
   logic        r_corr, r_unc;
   logic [4:0]  r_pos;

   assign out_fire     = s2_valid & bus.out_ready;
   assign s2_ready     = ~s2_valid | bus.out_ready;
   assign s1_adv       = s1_valid & s2_ready;
   // Ready looks through a full S1 that is about to move on: no bubble.
   assign bus.in_ready = ~s1_valid | s1_adv;
   assign in_fire      = bus.in_valid & bus.in_ready;

   // Stage 1: capture codeword and syndrome only on an accepted transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
      end else begin
         if (in_fire) begin
            s1_code <= bus.in_code;
            s1_syn  <= bus.in_code[18:6] ^ calc_par(bus.in_code[5:0]);
         end
         if (in_fire)     s1_valid <= 1'b1;
         else if (s1_adv) s1_valid <= 1'b0;
      end
   end

   // Column match; columns are all distinct so at most one hit.
   always_comb begin
      dec_data = s1_code[5:0];
      dec_corr = 1'b0;
      dec_unc  = 1'b0;
      dec_pos  = 5'd31;
      if (s1_syn != '0) begin
         for (int i = 0; i < 19; i++) begin
            if (s1_syn == col_of(i)) begin
               dec_corr = 1'b1;
               dec_pos  = 5'(i);
            end
         end
         if (!dec_corr)
            dec_unc = 1'b1;
         else if (dec_pos < 5'd6)
            dec_data[dec_pos[2:0]] = ~s1_code[dec_pos[2:0]];
      end
   end

   // Stage 2: result register, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         r_data   <= '0;
         r_corr   <= 1'b0;
         r_unc    <= 1'b0;
         r_pos    <= 5'd31;
      end else begin
         if (s1_adv) begin
            r_data <= dec_data;
            r_corr <= dec_corr;
            r_unc  <= dec_unc;
            r_pos  <= dec_pos;
         end
         if (s1_adv)        s2_valid <= 1'b1;
         else if (out_fire) s2_valid <= 1'b0;
      end
   end

   assign bus.out_valid         = s2_valid;
   assign bus.out_data          = r_data;
   assign bus.out_corrected     = r_corr;
   assign bus.out_uncorrectable = r_unc;
   assign bus.out_err_pos       = r_pos;

   // Statistics count delivered words only; clear beats a same-cycle bump.
   always_ff @(posedge clk) begin
      if (reset || cnt_clear) begin
         cnt_corrected     <= '0;
         cnt_uncorrectable <= '0;
      end else if (out_fire) begin
         if (r_corr && !(&cnt_corrected))
            cnt_corrected <= cnt_corrected + 1'b1;
         if (r_unc && !(&cnt_uncorrectable))
            cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
      end
   end

endmodule
